param_cpu_core: RTL
===================

Name: param_cpu_core

Overview:
Parametrised successor to the top-level fetch/execute CPU. Width, address space and register count are generic. Memory sits behind an external req/ack port instead of an internal array, so SDRAM-controller latency is tolerated. OUT/IN use valid/ready handshakes, HALT gives a status output instead of ending simulation, and RST returns to the code base. Instantiated by the board top, which supplies the code-section base address.

Parameters:
DATA_WIDTH, 8, register/operand/memory word width (>=4)
ADDR_WIDTH, 23, memory word-address width
NUM_REGS, 8, general registers r0..r(NUM_REGS-1); power of two, 2..2^DATA_WIDTH; r0 is accumulator A

Ports:
CLOCK_50  in  1  sole clock, rising edge
KEY  in  1  reset, synchronous, active-low (board KEY[0])
code_base  in  ADDR_WIDTH  address of first instruction; sampled at reset, RST and jumps
mem_req  out  1  memory request, held until ack
mem_we  out  1  1=write, 0=read; valid with mem_req
mem_addr  out  ADDR_WIDTH  word address
mem_wdata  out  DATA_WIDTH  write data
mem_rdata  in  DATA_WIDTH  read data, valid when mem_ack=1
mem_ack  in  1  one-cycle completion pulse
out_valid  out  1  OUT data available
out_ready  in  1  consumer accepts
out_data  out  DATA_WIDTH  OUT value
in_valid  in  1  producer has data
in_ready  out  1  core waiting on IN
in_data  in  DATA_WIDTH  IN value
halted  out  1  core stopped by HALT

Behaviour:
- Reset (KEY=0 at edge): state FETCH_OP; IP<=code_base; all registers, opcode/operand latches 0; mem_req, mem_we, out_valid, in_ready, halted 0; mem_addr, mem_wdata, out_data 0. Reset wins over every state, including mid-transaction. Any in-flight ack after reset is ignored.
- Instruction = 3 consecutive words: opcode, op1, op2. Register index = low log2(NUM_REGS) bits of operand.
- States: FETCH_OP -> FETCH_OP1 -> FETCH_OP2 -> EXECUTE -> (MEM_LOAD | MEM_STORE | OUT_WAIT | IN_WAIT | HALTED | FETCH_OP).
- Fetch: mem_req=1, mem_we=0, addr=IP, IP+1, IP+2 (mod 2^ADDR_WIDTH). On mem_ack, latch mem_rdata, drop req in the same edge, advance. Minimum 2 cycles per word (req cycle, ack cycle); ack arriving the same cycle req rises counts.
- mem_ack while mem_req=0: ignored.
- EXECUTE (1 cycle), opcodes:
  - 0 NOP: IP+=3.
  - 1 LOAD: read addr zext(op1); r[op2]<=rdata on ack; IP+=3.
  - 2 STORE: write r[op1] to addr zext(op2); IP+=3 on ack.
  - 3 ADD: A<=r[op1]+r[op2], mod 2^DATA_WIDTH.
  - 4 SUB: A<=r[op1]-r[op2], mod 2^DATA_WIDTH.
  - 5 OUT: out_data<=r[op1], out_valid=1 until out_valid&out_ready edge; then IP+=3.
  - 6 IN: in_ready=1 until in_valid&in_ready edge; r[op1]<=in_data; IP+=3.
  - 7 MOV: r[op2]<=r[op1].
  - 8 CMP (unsigned): A<=0 if r[op1]<r[op2], 1 if equal, else 2.
  - 9/10/11 JMPL/JMPE/JMPG: if A==0/1/2, IP<=code_base+zext(op1) (mod 2^ADDR_WIDTH); else IP+=3.
  - 12 RST: all registers 0, IP<=code_base.
  - 13 HALT: halted=1, stays in HALTED until reset; no bus activity.
  - Any other opcode: treated as NOP.
- Register reads use pre-execute values. ADD/SUB/CMP write A even when op1/op2 index A.
- IP arithmetic wraps modulo 2^ADDR_WIDTH, e.g. IP=2^ADDR_WIDTH-1 fetches at ..-1, 0, 1.
- Never two outstanding memory requests. mem_addr/mem_we/mem_wdata stable while mem_req=1.

Test Plan:
- Reset, code_base=0x100, zero-wait memory: program LOAD 0x20->r1, LOAD 0x21->r2, ADD r1,r2, OUT r0, HALT with mem[0x20]=200, mem[0x21]=100 -> out_data=44 (wrap), halted=1, IP=0x10C.
- Memory ack delayed 5 cycles on every access -> identical results. mem_req held continuously; address/we never change while pending.
- CMP loop: r1=3 vs r2=5 -> A=0, JMPL op1=0 taken to code_base. r1=r2=5 -> A=1, JMPL falls through to IP+3. r1=7 -> A=2, JMPG taken.
- OUT with out_ready held 0 for 10 cycles -> out_valid held, out_data=r[op1] stable, no fetch. IN with in_data=0x5A after 4 cycles -> r3=0x5A, in_ready drops the next cycle.
- STORE r1 (0xAB) to 0x30, then LOAD 0x30->r4 -> mem_we=1, addr 0x30, wdata 0xAB; r4=0xAB. RST -> all registers 0, IP=code_base.
- KEY=0 asserted mid-fetch with mem_req=1 -> next edge mem_req=0, state FETCH_OP, IP=code_base; late mem_ack ignored. Unknown opcode 0xFF behaves as NOP.

Source files
------------

// File: rtl/param_cpu_core.sv
// Parametrised fetch/execute core: 3-word instructions fetched over a req/ack memory port,
// with valid/ready OUT/IN channels and a HALT status output.
module param_cpu_core #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 23,
    parameter int NUM_REGS   = 8
) (
    input  logic                  CLOCK_50,
    input  logic                  KEY,
    input  logic [ADDR_WIDTH-1:0] code_base,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  halted
);
    localparam int RIDX_W = $clog2(NUM_REGS);

    localparam logic [DATA_WIDTH-1:0] OP_LOAD  = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] OP_STORE = DATA_WIDTH'(2);
    localparam logic [DATA_WIDTH-1:0] OP_ADD   = DATA_WIDTH'(3);
    localparam logic [DATA_WIDTH-1:0] OP_SUB   = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] OP_OUT   = DATA_WIDTH'(5);
    localparam logic [DATA_WIDTH-1:0] OP_IN    = DATA_WIDTH'(6);
    localparam logic [DATA_WIDTH-1:0] OP_MOV   = DATA_WIDTH'(7);
    localparam logic [DATA_WIDTH-1:0] OP_CMP   = DATA_WIDTH'(8);
    localparam logic [DATA_WIDTH-1:0] OP_JMPL  = DATA_WIDTH'(9);
    localparam logic [DATA_WIDTH-1:0] OP_JMPE  = DATA_WIDTH'(10);
    localparam logic [DATA_WIDTH-1:0] OP_JMPG  = DATA_WIDTH'(11);
    localparam logic [DATA_WIDTH-1:0] OP_RST   = DATA_WIDTH'(12);
    localparam logic [DATA_WIDTH-1:0] OP_HALT  = DATA_WIDTH'(13);

    typedef enum logic [3:0] {
        FETCH_OP, FETCH_OP1, FETCH_OP2, EXECUTE,
        MEM_LOAD, MEM_STORE, OUT_WAIT, IN_WAIT, HALTED
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ip_q, ip_d, addr_q, addr_d, fetch_off, jmp_tgt;
    logic [DATA_WIDTH-1:0] opc_q, opc_d, op1_q, op1_d, op2_q, op2_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d, outd_q, outd_d, a_val, b_val;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic                  req_q, req_d, we_q, we_d, outv_q, outv_d;
    logic                  inr_q, inr_d, halt_q, halt_d;

    function automatic logic [RIDX_W-1:0] ridx(input logic [DATA_WIDTH-1:0] v);
        return v[RIDX_W-1:0];
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] zext(input logic [DATA_WIDTH-1:0] v);
        return ADDR_WIDTH'(v);
    endfunction

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign out_valid = outv_q;
    assign out_data  = outd_q;
    assign in_ready  = inr_q;
    assign halted    = halt_q;

    always_comb begin
        state_d = state_q;
        ip_d    = ip_q;
        opc_d   = opc_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        regs_d  = regs_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        outv_d  = outv_q;
        outd_d  = outd_q;
        inr_d   = inr_q;
        halt_d  = halt_q;
        a_val   = regs_q[ridx(op1_q)];
        b_val   = regs_q[ridx(op2_q)];
        jmp_tgt = code_base + zext(op1_q);
        fetch_off = (state_q == FETCH_OP1) ? ADDR_WIDTH'(1) :
                    (state_q == FETCH_OP2) ? ADDR_WIDTH'(2) : '0;

        case (state_q)
            FETCH_OP, FETCH_OP1, FETCH_OP2: begin
                if (!req_q) begin
                    req_d  = 1'b1;
                    we_d   = 1'b0;
                    addr_d = ip_q + fetch_off;
                end else if (mem_ack) begin
                    req_d = 1'b0;
                    if (state_q == FETCH_OP) begin
                        opc_d   = mem_rdata;
                        state_d = FETCH_OP1;
                    end else if (state_q == FETCH_OP1) begin
                        op1_d   = mem_rdata;
                        state_d = FETCH_OP2;
                    end else begin
                        op2_d   = mem_rdata;
                        state_d = EXECUTE;
                    end
                end
            end
            EXECUTE: begin
                // Default is a plain advance; multi-cycle ops hold IP until they complete.
                state_d = FETCH_OP;
                ip_d    = ip_q + ADDR_WIDTH'(3);
                case (opc_q)
                    OP_LOAD:  begin state_d = MEM_LOAD;  ip_d = ip_q; end
                    OP_STORE: begin state_d = MEM_STORE; ip_d = ip_q; end
                    OP_ADD:   regs_d[0] = a_val + b_val;
                    OP_SUB:   regs_d[0] = a_val - b_val;
                    OP_OUT: begin
                        outd_d  = a_val;
                        outv_d  = 1'b1;
                        state_d = OUT_WAIT;
                        ip_d    = ip_q;
                    end
                    OP_IN: begin
                        inr_d   = 1'b1;
                        state_d = IN_WAIT;
                        ip_d    = ip_q;
                    end
                    OP_MOV:   regs_d[ridx(op2_q)] = a_val;
                    OP_CMP:   regs_d[0] = (a_val < b_val)  ? DATA_WIDTH'(0) :
                                          (a_val == b_val) ? DATA_WIDTH'(1) : DATA_WIDTH'(2);
                    OP_JMPL:  if (regs_q[0] == DATA_WIDTH'(0)) ip_d = jmp_tgt;
                    OP_JMPE:  if (regs_q[0] == DATA_WIDTH'(1)) ip_d = jmp_tgt;
                    OP_JMPG:  if (regs_q[0] == DATA_WIDTH'(2)) ip_d = jmp_tgt;
                    OP_RST: begin
                        for (int i = 0; i < NUM_REGS; i++) regs_d[i] = '0;
                        ip_d = code_base;
                    end
                    OP_HALT: begin
                        halt_d  = 1'b1;
                        state_d = HALTED;
                        ip_d    = ip_q;
                    end
                    default: ;
                endcase
            end
            MEM_LOAD, MEM_STORE: begin
                if (!req_q) begin
                    req_d = 1'b1;
                    if (state_q == MEM_LOAD) begin
                        we_d   = 1'b0;
                        addr_d = zext(op1_q);
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = zext(op2_q);
                        wdata_d = a_val;
                    end
                end else if (mem_ack) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    if (state_q == MEM_LOAD) regs_d[ridx(op2_q)] = mem_rdata;
                    ip_d    = ip_q + ADDR_WIDTH'(3);
                    state_d = FETCH_OP;
                end
            end
            OUT_WAIT: begin
                if (out_ready) begin
                    outv_d  = 1'b0;
                    ip_d    = ip_q + ADDR_WIDTH'(3);
                    state_d = FETCH_OP;
                end
            end
            IN_WAIT: begin
                if (in_valid) begin
                    regs_d[ridx(op1_q)] = in_data;
                    inr_d   = 1'b0;
                    ip_d    = ip_q + ADDR_WIDTH'(3);
                    state_d = FETCH_OP;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!KEY) begin
            state_q <= FETCH_OP;
            ip_q    <= code_base;
            opc_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            regs_q  <= '{default: '0};
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            outv_q  <= 1'b0;
            outd_q  <= '0;
            inr_q   <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ip_q    <= ip_d;
            opc_q   <= opc_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            regs_q  <= regs_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            outv_q  <= outv_d;
            outd_q  <= outd_d;
            inr_q   <= inr_d;
            halt_q  <= halt_d;
        end
    end
endmodule
